// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline M stage and an addr_ok/data_ok memory bus:
// aligns and replicates stores, extracts and extends loads, traps misaligned accesses.
module mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                req_ready,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                stall,
  output logic                adel,
  output logic                ades
);
  localparam int unsigned LANES       = DATA_W / 8;
  localparam int unsigned OFF_W       = $clog2(LANES);
  localparam int unsigned LANE_CALC_W = OFF_W + 1;
  localparam int unsigned REPS        = DATA_W / 32;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} stateT;

  stateT                  state, stateNext;
  logic                   isStore, isWord, isHalf, misaligned;
  logic                   accept, complete;
  logic [2:0]             sizeBytes;
  logic [LANES-1:0]       sizeMask;
  logic [LANE_CALC_W-1:0] laneCalc;
  logic [OFF_W-1:0]       reqLane, laneReg;
  logic [31:0]            repData;
  logic [2:0]             opReg;
  logic [DATA_W-1:0]      rdataShift;
  logic [31:0]            loadWord, loadResult;

  // Request decode: size, alignment and the lowest lane the access occupies.
  always_comb begin
    isStore    = req_op inside {OP_SB, OP_SH, OP_SW};
    isWord     = req_op inside {OP_LW, OP_SW};
    isHalf     = req_op inside {OP_LH, OP_LHU, OP_SH};
    misaligned = (isWord && (req_addr[1:0] != 2'b00)) || (isHalf && req_addr[0]);
    sizeBytes  = isWord ? 3'd4 : (isHalf ? 3'd2 : 3'd1);
    sizeMask   = LANES'(isWord ? 4'hF : (isHalf ? 4'h3 : 4'h1));
    // Big-endian places byte 0 on the top lane; the mirrored window keeps bit order natural.
    if (BIG_ENDIAN)
      laneCalc = LANE_CALC_W'(LANES) - LANE_CALC_W'(req_addr[OFF_W-1:0]) - LANE_CALC_W'(sizeBytes);
    else
      laneCalc = LANE_CALC_W'(req_addr[OFF_W-1:0]);
    reqLane = laneCalc[OFF_W-1:0];
    repData = isWord ? req_wdata : (isHalf ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state plus the combinational handshake outputs.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    complete  = 1'b0;
    stall     = 1'b0;
    req_ready = 1'b0;
    adel      = 1'b0;
    ades      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid && !misaligned;
        adel      = req_valid && misaligned && !isStore && !flush;
        ades      = req_valid && misaligned && isStore && !flush;
        if (req_valid && !misaligned && !flush) begin
          accept    = 1'b1;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        stall = 1'b1;
        if (flush) begin
          // An address the bus took in the flush cycle still owes a data phase.
          stateNext = (mem_addr_ok && !mem_data_ok) ? DRAIN : IDLE;
        end else if (mem_addr_ok) begin
          complete  = mem_data_ok;
          stateNext = mem_data_ok ? IDLE : DATA;
        end
      end
      DATA: begin
        stall = 1'b1;
        if (mem_data_ok) begin
          complete  = !flush;
          stateNext = IDLE;
        end else if (flush) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: if (mem_data_ok) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!resetn) begin
      stall = 1'b0;
      adel  = 1'b0;
      ades  = 1'b0;
    end
  end

  assign mem_req = (state == ADDR);

  // Bus payload captured at acceptance and held for the whole access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      opReg     <= OP_LW;
      laneReg   <= '0;
    end else if (accept) begin
      mem_addr  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      mem_wr    <= isStore;
      mem_wstrb <= isStore ? (sizeMask << reqLane) : '0;
      mem_wdata <= {REPS{repData}};
      opReg     <= req_op;
      laneReg   <= reqLane;
    end
  end

  // Load extraction and extension; stores report zero.
  always_comb begin
    rdataShift = mem_rdata >> {laneReg, 3'b000};
    loadWord   = rdataShift[31:0];
    case (opReg)
      OP_LW:   loadResult = loadWord;
      OP_LH:   loadResult = {{16{loadWord[15]}}, loadWord[15:0]};
      OP_LHU:  loadResult = {16'h0000, loadWord[15:0]};
      OP_LB:   loadResult = {{24{loadWord[7]}}, loadWord[7:0]};
      OP_LBU:  loadResult = {24'h000000, loadWord[7:0]};
      default: loadResult = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= complete;
      if (complete) rsp_data <= loadResult;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit little-endian and a 64-bit big-endian instance run in lockstep
// against a byte-address reference model, with table vectors, random accesses and corner sequences.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, flush, mem_addr_ok, mem_data_ok;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        ready32, memReq32, memWr32, rspValid32, stall32, adel32, ades32;
  logic [31:0] memAddr32, wdata32, rspData32;
  logic [3:0]  strb32;
  logic        ready64, memReq64, memWr64, rspValid64, stall64, adel64, ades64;
  logic [31:0] memAddr64, rspData64;
  logic [63:0] wdata64;
  logic [7:0]  strb64;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .BIG_ENDIAN(1'b0), .ADDR_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready32), .flush(flush), .mem_req(memReq32), .mem_wr(memWr32),
    .mem_addr(memAddr32), .mem_wstrb(strb32), .mem_wdata(wdata32), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(rdata32), .rsp_valid(rspValid32), .rsp_data(rspData32),
    .stall(stall32), .adel(adel32), .ades(ades32));

  mem_access_unit #(.DATA_W(64), .BIG_ENDIAN(1'b1), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready64), .flush(flush), .mem_req(memReq64), .mem_wr(memWr64),
    .mem_addr(memAddr64), .mem_wstrb(strb64), .mem_wdata(wdata64), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(rdata64), .rsp_valid(rspValid64), .rsp_data(rspData64),
    .stall(stall64), .adel(adel64), .ades(ades64));

  typedef struct packed {
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [31:0] rsp;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, wd;
    logic [63:0] rd;
    logic [31:0] a32, a64;
    logic [3:0]  strb32;
    logic [31:0] wdat32, rsp32;
    logic [7:0]  strb64;
    logic [31:0] rsp64;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int opSize(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd7) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  // Memory view: each lane holds one byte address; the access covers [addr, addr+size).
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [63:0] rd, input int lanes, input bit be);
    exp_t        e;
    int          size;
    bit          st;
    logic [31:0] base, ba, k, raw;
    logic [7:0]  bytes [4];
    e    = '0;
    size = opSize(op);
    st   = (op >= 3'd5);
    base = addr & ~(32'(lanes) - 32'd1);
    e.addr = base;
    for (int j = 0; j < 4; j++) bytes[j] = 8'h00;
    for (int i = 0; i < lanes; i++) begin
      ba = be ? base + 32'(lanes - 1 - i) : base + 32'(i);
      k  = ba - addr;
      if (k < 32'(size)) begin
        if (st) e.strb[i] = 1'b1;
        bytes[k[1:0]] = rd[i*8 +: 8];
      end
      e.wdata[i*8 +: 8] = wd[(i % size)*8 +: 8];
    end
    raw = '0;
    for (int j = 0; j < size; j++)
      if (be) raw = (raw << 8) | 32'(bytes[j]);
      else    raw = raw | (32'(bytes[j]) << (8*j));
    case (op)
      3'd0:    e.rsp = raw;
      3'd1:    e.rsp = {{16{raw[15]}}, raw[15:0]};
      3'd2:    e.rsp = {16'h0, raw[15:0]};
      3'd3:    e.rsp = {{24{raw[7]}}, raw[7:0]};
      3'd4:    e.rsp = {24'h0, raw[7:0]};
      default: e.rsp = 32'h0;
    endcase
    return e;
  endfunction

  task automatic scrambleRdata();
    rdata32 = $urandom;
    rdata64 = {$urandom, $urandom};
  endtask

  task automatic checkBus(input string tag, input bit st, input exp_t e32, input exp_t e64);
    chk({tag, "_mem_req"}, {memReq32, memReq64}, 2'b11);
    chk({tag, "_addr32"}, memAddr32, e32.addr);
    chk({tag, "_addr64"}, memAddr64, e64.addr);
    chk({tag, "_wr"}, {memWr32, memWr64}, {st, st});
    chk({tag, "_strb32"}, strb32, e32.strb[3:0]);
    chk({tag, "_strb64"}, strb64, e64.strb);
    if (st) begin
      chk({tag, "_wdata32"}, wdata32, e32.wdata[31:0]);
      chk({tag, "_wdata64"}, wdata64, e64.wdata);
    end
    chk({tag, "_stall"}, {stall32, stall64}, 2'b11);
    chk({tag, "_ready"}, {ready32, ready64}, 2'b00);
  endtask

  // One aligned access with aDly idle cycles before addr_ok and dDly before data_ok.
  task automatic runAccess(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [63:0] rd, input int aDly, input int dDly, input bit combined,
                           input exp_t e32, input exp_t e64);
    bit st = (op >= 3'd5);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("req_ready", {ready32, ready64}, 2'b11);
    chk("stall_req", {stall32, stall64}, 2'b11);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 0; c <= aDly; c++) begin
      if (c == aDly) begin
        mem_addr_ok = 1'b1;
        if (combined) begin mem_data_ok = 1'b1; rdata32 = rd[31:0]; rdata64 = rd; end
      end
      @(negedge clk);
      checkBus("addr", st, e32, e64);
      @(posedge clk); #1;
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; scrambleRdata();
    if (!combined) begin
      for (int c = 0; c <= dDly; c++) begin
        if (c == dDly) begin mem_data_ok = 1'b1; rdata32 = rd[31:0]; rdata64 = rd; end
        @(negedge clk);
        chk("data_mem_req", {memReq32, memReq64}, 2'b00);
        chk("data_stall", {stall32, stall64}, 2'b11);
        chk("data_rsp_early", {rspValid32, rspValid64}, 2'b00);
        @(posedge clk); #1;
      end
      mem_data_ok = 1'b0; scrambleRdata();
    end
    @(negedge clk);
    chk("rsp_valid", {rspValid32, rspValid64}, 2'b11);
    chk("rsp_data32", rspData32, e32.rsp);
    chk("rsp_data64", rspData64, e64.rsp);
    chk("rsp_stall", {stall32, stall64}, 2'b00);
    chk("rsp_ready", {ready32, ready64}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_once", {rspValid32, rspValid64}, 2'b00);
    chk("rsp_hold32", rspData32, e32.rsp);
  endtask

  task automatic runMisaligned(input logic [2:0] op, input logic [31:0] addr);
    bit st = (op >= 3'd5);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = $urandom;
    @(negedge clk);
    chk("mis_adel", {adel32, adel64}, {!st, !st});
    chk("mis_ades", {ades32, ades64}, {st, st});
    chk("mis_stall", {stall32, stall64}, 2'b00);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_mem_req", {memReq32, memReq64}, 2'b00);
    chk("mis_pulse", {adel32, adel64, ades32, ades64}, 4'b0000);
    chk("mis_rsp", {rspValid32, rspValid64}, 2'b00);
    chk("mis_ready", {ready32, ready64}, 2'b11);
  endtask

  task automatic checkIdleReset(input string tag);
    chk({tag, "_mem_req"}, {memReq32, memReq64, memWr32, memWr64}, 4'b0000);
    chk({tag, "_pulses"}, {rspValid32, rspValid64, adel32, adel64, ades32, ades64}, 6'b0);
    chk({tag, "_strb"}, {strb32, strb64}, 12'h000);
    chk({tag, "_wdata"}, {wdata32, wdata64[31:0]}, 64'h0);
    chk({tag, "_addr"}, {memAddr32, memAddr64}, 64'h0);
    chk({tag, "_rsp_data"}, {rspData32, rspData64}, 64'h0);
    chk({tag, "_stall"}, {stall32, stall64}, 2'b00);
    chk({tag, "_ready"}, {ready32, ready64}, 2'b11);
  endtask

  initial begin
    vec_t vecs [9];
    exp_t e32, e64;
    vecs[0] = '{3'd5, 32'h1003, 32'hAB, 64'h0, 32'h1000, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 8'h10, 32'h0};
    vecs[1] = '{3'd3, 32'h2002, 32'h0, 64'hA1B2C3D4_12F45678, 32'h2000, 32'h2000, 4'b0, 32'h0, 32'hFFFFFFF4, 8'h00, 32'hFFFFFFC3};
    vecs[2] = '{3'd4, 32'h2002, 32'h0, 64'hA1B2C3D4_12F45678, 32'h2000, 32'h2000, 4'b0, 32'h0, 32'h000000F4, 8'h00, 32'h000000C3};
    vecs[3] = '{3'd0, 32'h8, 32'h0, 64'h11223344_55667788, 32'h8, 32'h8, 4'b0, 32'h0, 32'h55667788, 8'h00, 32'h11223344};
    vecs[4] = '{3'd7, 32'hC, 32'hDEADBEEF, 64'h0, 32'hC, 32'h8, 4'b1111, 32'hDEADBEEF, 32'h0, 8'h0F, 32'h0};
    vecs[5] = '{3'd1, 32'h6, 32'h0, 64'h8899AABB_CCDDEEFF, 32'h4, 32'h0, 4'b0, 32'h0, 32'hFFFFCCDD, 8'h00, 32'hFFFFEEFF};
    vecs[6] = '{3'd6, 32'h2, 32'h1234, 64'h0, 32'h0, 32'h0, 4'b1100, 32'h12341234, 32'h0, 8'h30, 32'h0};
    vecs[7] = '{3'd2, 32'h0, 32'h0, 64'hF00D0000_00008001, 32'h0, 32'h0, 4'b0, 32'h0, 32'h00008001, 8'h00, 32'h0000F00D};
    vecs[8] = '{3'd5, 32'hFFFFFFFF, 32'h5A, 64'h0, 32'hFFFFFFFC, 32'hFFFFFFF8, 4'b1000, 32'h5A5A5A5A, 32'h0, 8'h01, 32'h0};

    resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; scrambleRdata();
    #12;
    checkIdleReset("reset");
    @(negedge clk); resetn = 1'b1;

    // Table vectors with spec-derived expectations.
    for (int i = 0; i < 9; i++) begin
      e32 = '0; e64 = '0;
      e32.addr = vecs[i].a32; e32.strb = {4'b0, vecs[i].strb32}; e32.wdata = {32'h0, vecs[i].wdat32};
      e32.rsp = vecs[i].rsp32;
      e64.addr = vecs[i].a64; e64.strb = vecs[i].strb64; e64.wdata = {2{vecs[i].wdat32}};
      e64.rsp = vecs[i].rsp64;
      runAccess(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].rd, i % 3, i % 2, i == 3, e32, e64);
    end

    // Slow bus: address accepted after 3 cycles, data after 2 more.
    e32 = model(3'd0, 32'h40, 32'h0, 64'hCAFEF00D_0BADBEEF, 4, 1'b0);
    e64 = model(3'd0, 32'h40, 32'h0, 64'hCAFEF00D_0BADBEEF, 8, 1'b1);
    runAccess(3'd0, 32'h40, 32'h0, 64'hCAFEF00D_0BADBEEF, 3, 2, 1'b0, e32, e64);

    runMisaligned(3'd1, 32'h3001);
    runMisaligned(3'd7, 32'h0002);
    runMisaligned(3'd0, 32'h0003);

    // Flush in DATA: drain the data phase silently.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fdata_stall", {stall32, stall64}, 2'b11);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_stall", {stall32, stall64}, 2'b00);
    chk("drain_ready", {ready32, ready64}, 2'b00);
    chk("drain_mem_req", {memReq32, memReq64}, 2'b00);
    @(posedge clk); #1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("drain_ready_dok", {ready32, ready64}, 2'b00);
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("drain_no_rsp", {rspValid32, rspValid64}, 2'b00);
    chk("drain_done_ready", {ready32, ready64}, 2'b11);

    // Flush in ADDR: request withdrawn immediately.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h20; req_wdata = 32'h01020304;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("faddr_mem_req", {memReq32, memReq64}, 2'b11);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("faddr_idle", {memReq32, memReq64, rspValid32, rspValid64, ready32, ready64}, 6'b000011);
      @(posedge clk); #1;
    end

    // Reset in the middle of an access.
    req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", {memReq32, memReq64}, 2'b11);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checkIdleReset("rst_mid");
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", {rspValid32, rspValid64, memReq32, memReq64}, 4'b0000);
      @(posedge clk); #1;
    end

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [31:0] addr, wd;
      logic [63:0] rd;
      int          size;
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd   = $urandom;
      rd   = {$urandom, $urandom};
      size = opSize(op);
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
      if ((addr % 32'(size)) != 0) begin
        runMisaligned(op, addr);
      end else begin
        e32 = model(op, addr, wd, rd, 4, 1'b0);
        e64 = model(op, addr, wd, rd, 8, 1'b1);
        runAccess(op, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, e32, e64);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
